// File: rtl/scoreboard_display_mux.sv
// Two-digit common-anode seven-segment scan driver fed by the scoreboard BCD counter.
// Latency: inputs snapshotted at frame start, visible at first SHOW0 cycle (DEAD_CYCLES later).
// Backpressure: none; free-running scan, inputs sampled once per frame so frames never tear.
module scoreboard_display_mux #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       blank_lz,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    snap1_q, snap1_d;
  logic [3:0]    snap0_q, snap0_d;
  logic          snap_lz_q, snap_lz_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a lone g segment (dash).
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign frame_start = (state_q == BLANK0) && (cnt_q == '0);

  // Slot sequencing, frame snapshot, and next anode/segment drive.
  // Outputs are derived from the next state and next snapshot so they switch on
  // the same edge as the state, even when the blank slot is a single cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    snap1_d   = snap1_q;
    snap0_d   = snap0_q;
    snap_lz_d = snap_lz_q;
    an_d      = 2'b11;
    seg_d     = 7'h7F;

    if (frame_start) begin
      snap1_d   = bcd1;
      snap0_d   = bcd0;
      snap_lz_d = blank_lz;
    end

    case (state_q)
      BLANK0: if (cnt_q == BLANK_LAST) begin state_d = SHOW0;  cnt_d = '0; end
      SHOW0:  if (cnt_q == SHOW_LAST)  begin state_d = BLANK1; cnt_d = '0; end
      BLANK1: if (cnt_q == BLANK_LAST) begin state_d = SHOW1;  cnt_d = '0; end
      SHOW1:  if (cnt_q == SHOW_LAST)  begin state_d = BLANK0; cnt_d = '0; end
      default: begin state_d = BLANK0; cnt_d = '0; end
    endcase

    case (state_d)
      SHOW0: begin
        an_d  = 2'b10;
        seg_d = decode(snap0_d);
      end
      SHOW1: begin
        if (!(snap_lz_d && (snap1_d == 4'd0))) begin
          an_d  = 2'b01;
          seg_d = decode(snap1_d);
        end
      end
      default: begin
        an_d  = 2'b11;
        seg_d = 7'h7F;
      end
    endcase
  end

  // State, slot counter, snapshot and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BLANK0;
      cnt_q     <= '0;
      snap1_q   <= 4'd0;
      snap0_q   <= 4'd0;
      snap_lz_q <= 1'b0;
      an_q      <= 2'b11;
      seg_q     <= 7'h7F;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap1_q   <= snap1_d;
      snap0_q   <= snap0_d;
      snap_lz_q <= snap_lz_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_scoreboard_display_mux.sv
// Bench for scoreboard_display_mux with SCAN_DIV=8, DEAD_CYCLES=2.
// Reference: frame-position model (16-cycle frame) plus directed literal checks.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
module tb_scoreboard_display_mux;

  localparam int SD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = 2 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd1 = 4'd0;
  logic [3:0] bcd0 = 4'd0;
  logic       blank_lz = 1'b0;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int total  = 0;
  int passed = 0;

  scoreboard_display_mux #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .reset(rst), .bcd1(bcd1), .bcd0(bcd0), .blank_lz(blank_lz),
    .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Model: position within the frame and the values latched at frame start.
  int         p = 0;
  logic [3:0] ms1 = 4'd0, ms0 = 4'd0;
  logic       mlz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= 0; ms1 <= 4'd0; ms0 <= 4'd0; mlz <= 1'b0;
    end else begin
      if (p == 0) begin
        ms1 <= bcd1; ms0 <= bcd0; mlz <= blank_lz;
      end
      p <= (p + 1) % FRAME;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d <= 4'd9) ? tbl[d] : 7'h3F;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t p=%0d)", nm, act, exp, $time, p);
  endtask

  // Every cycle: outputs must match what the frame position and snapshot imply.
  always @(negedge clk) begin
    logic [1:0] ea;
    logic [6:0] es;
    ea = 2'b11; es = 7'h7F;
    if (p >= DC && p < SD) begin
      ea = 2'b10; es = seg_of(ms0);
    end else if (p >= SD + DC) begin
      if (!(mlz && ms1 == 4'd0)) begin ea = 2'b01; es = seg_of(ms1); end
    end
    chk("model an", {6'd0, an}, {6'd0, ea});
    chk("model seg", {1'b0, seg}, {1'b0, es});
    chk("model frame_start", {7'd0, frame_start}, {7'd0, 1'(p == 0)});
    chk("an never 00", {7'd0, 1'(an == 2'b00)}, 8'd0);
  end

  // Advance at least one falling edge, stopping when the model position is tgt.
  task automatic go_to(input int tgt);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (p != tgt && n < 40);
    if (p != tgt) begin
      total++;
      $display("FAIL go_to timeout: position %0d expected %0d", p, tgt);
    end
  endtask

  task automatic set_frame(input logic [3:0] b1, input logic [3:0] b0, input logic lz);
    go_to(0);
    bcd1 = b1; bcd0 = b0; blank_lz = lz;
  endtask

  initial begin
    #1 rst = 1'b1;
    #22 rst = 1'b0;                         // released between edges
    chk("reset frame_start", {7'd0, frame_start}, 8'd1);
    chk("reset an", {6'd0, an}, 8'h03);
    chk("reset seg", {1'b0, seg}, 8'h7F);

    // Scenario 1: reset asserted in the middle of SHOW1.
    set_frame(4'd5, 4'd6, 1'b0);
    go_to(12);
    chk("pre-reset an", {6'd0, an}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("async reset an", {6'd0, an}, 8'h03);
    chk("async reset seg", {1'b0, seg}, 8'h7F);
    chk("async reset frame_start", {7'd0, frame_start}, 8'd1);
    rst = 1'b0;
    #1;
    chk("post-release frame_start", {7'd0, frame_start}, 8'd1);
    go_to(1);
    chk("post-release blank an", {6'd0, an}, 8'h03);
    chk("post-release frame_start low", {7'd0, frame_start}, 8'd0);
    go_to(2);
    chk("post-release show0 an", {6'd0, an}, 8'h02);
    chk("post-release show0 seg", {1'b0, seg}, 8'h02);

    // Scenario 2: 42 without blanking.
    set_frame(4'd4, 4'd2, 1'b0);
    go_to(1);
    chk("s2 blank seg", {1'b0, seg}, 8'h7F);
    go_to(3);
    chk("s2 show0 an", {6'd0, an}, 8'h02);
    chk("s2 show0 seg", {1'b0, seg}, 8'h24);
    go_to(9);
    chk("s2 blank1 an", {6'd0, an}, 8'h03);
    go_to(11);
    chk("s2 show1 an", {6'd0, an}, 8'h01);
    chk("s2 show1 seg", {1'b0, seg}, 8'h19);

    // Scenario 3: 07 with and without leading-zero blanking.
    set_frame(4'd0, 4'd7, 1'b1);
    go_to(3);
    chk("s3 show0 seg", {1'b0, seg}, 8'h78);
    go_to(11);
    chk("s3 lz blank an", {6'd0, an}, 8'h03);
    chk("s3 lz blank seg", {1'b0, seg}, 8'h7F);
    set_frame(4'd0, 4'd7, 1'b0);
    go_to(11);
    chk("s3 no-lz an", {6'd0, an}, 8'h01);
    chk("s3 no-lz seg", {1'b0, seg}, 8'h40);

    // Scenario 4: bcd0 changes mid-SHOW0; the frame must keep showing 3.
    set_frame(4'd1, 4'd3, 1'b0);
    go_to(4);
    bcd0 = 4'd8;
    go_to(5);
    chk("s4 tear-free seg", {1'b0, seg}, 8'h30);
    go_to(7);
    chk("s4 tear-free last seg", {1'b0, seg}, 8'h30);
    go_to(3);
    chk("s4 next frame seg", {1'b0, seg}, 8'h00);

    // Scenario 5: invalid codes render as dash; lz does not blank a nonzero digit.
    set_frame(4'hF, 4'hB, 1'b1);
    go_to(3);
    chk("s5 show0 dash", {1'b0, seg}, 8'h3F);
    go_to(11);
    chk("s5 show1 an", {6'd0, an}, 8'h01);
    chk("s5 show1 dash", {1'b0, seg}, 8'h3F);

    // Scenario 6: sweep 00..99, one value per frame.
    for (int v = 0; v < 100; v++) begin
      set_frame(4'(v / 10), 4'(v % 10), 1'(v % 2));
    end
    go_to(0);
    go_to(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/scoreboard_display_mux.md
# scoreboard_display_mux

Consumer end of the scoreboard's BCD digit interface: takes the two-digit BCD value (`bcd1`, `bcd0`) produced by the scoreboard counter and drives a time-multiplexed, two-digit, common-anode seven-segment display. Digit values are snapshotted once per frame so a count change never tears a frame. Leading-zero blanking is optional, invalid BCD codes render as a dash, and dead time between digits suppresses ghosting.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot (blank plus show). At 100 MHz this gives 1 kHz per digit. Legal range is 2 to 2^20.
- `DEAD_CYCLES`, default 16: blanked cycles at the start of each digit slot. Legal range is 1 ≤ DEAD_CYCLES < SCAN_DIV.
- `clk  in  1`: single clock; all state changes on its rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `bcd1  in  4`: most significant BCD digit from the counter.
- `bcd0  in  4`: least significant BCD digit from the counter.
- `blank_lz  in  1`: 1 means blank digit 1 when it is 0.
- `an  out  2`: active-low anode enables. `an[0]` is digit 0 (LSD) and `an[1]` is digit 1 (MSD).
- `seg  out  7`: active-low segments, ordered {g,f,e,d,c,b,a}.
- `frame_start  out  1`: high for 1 cycle at the start of each frame, in the snapshot cycle.

## Operation
- Four-state FSM, cycling BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0.
- Slot counter `cnt` has width $clog2(SCAN_DIV) and is cleared on every state change.
  - BLANK states last DEAD_CYCLES cycles.
  - SHOW states last SCAN_DIV−DEAD_CYCLES cycles.
  - One frame is 2·SCAN_DIV cycles.
- Snapshot: `bcd1`, `bcd0` and `blank_lz` are captured into internal registers on the closing edge of the cycle where state = BLANK0 and cnt = 0. All display decisions for that frame use the snapshot only.
- `frame_start` = (state == BLANK0) && (cnt == 0), decoded combinationally from registered state.
- Outputs by state:
  - BLANK0 and BLANK1: `an`=2'b11, `seg`=7'h7F.
  - SHOW0: `an`=2'b10, `seg`=decode(snap0).
  - SHOW1: `an`=2'b01, `seg`=decode(snap1).
  - SHOW1 when snap_lz=1 and snap1=0: `an`=2'b11, `seg`=7'h7F (leading zero blanked).
  - Digit 0 is never blanked.
- Decode table (active low):

| Code | seg |
|---|---|
| 0 | 7'h40 |
| 1 | 7'h79 |
| 2 | 7'h24 |
| 3 | 7'h30 |
| 4 | 7'h19 |
| 5 | 7'h12 |
| 6 | 7'h02 |
| 7 | 7'h78 |
| 8 | 7'h00 |
| 9 | 7'h10 |
| 10–15 (invalid) | 7'h3F (dash, only g lit) |

- Reset (async, immediate):
  - State = BLANK0, cnt=0, snapshot registers = 0, snap_lz=0.
  - `an`=2'b11, `seg`=7'h7F, `frame_start`=1 (BLANK0, cnt 0).
  - Reset asserted mid-frame aborts the frame with no partial digit output.
- Inputs are synchronous to `clk`, so no synchronizers are required.

## Timing
- `an` and `seg` are registered and change on the same edge that the state changes. `an` is low exactly during SHOW-state cycles.
- Latency from input to display: a value present during a frame's snapshot cycle appears at the first SHOW0 cycle, DEAD_CYCLES cycles later. Changes after the snapshot appear in the next frame, at most 2·SCAN_DIV+DEAD_CYCLES cycles later.
- After reset deasserts, the first edge captures the snapshot and frame_start has been high since reset.
- `cnt` terminal values are DEAD_CYCLES−1 (blank) and SCAN_DIV−DEAD_CYCLES−1 (show). At terminal count the state advances and `cnt` wraps to 0 on the same edge.
- Each anode is never driven low in consecutive slots without ≥ DEAD_CYCLES blank cycles between them.

## Test plan
All scenarios use SCAN_DIV=8, DEAD_CYCLES=2.
1. Reset during SHOW1:
   - `an`=11, `seg`=7F without waiting for a clock edge.
   - After release, frame_start is high in the first cycle.
   - Then 2 blank cycles, followed by SHOW0.
2. `bcd1`=4, `bcd0`=2, `blank_lz`=0:
   - Repeating 16-cycle frame: 2 cycles of 11/7F, 6 cycles of an=10/seg=24, 2 cycles of 11/7F, 6 cycles of an=01/seg=19.
3. `bcd1`=0, `bcd0`=7:
   - With `blank_lz`=1: SHOW1 gives an=11/seg=7F, and SHOW0 gives seg=78.
   - With `blank_lz`=0: SHOW1 gives an=01/seg=40.
4. Tear-free snapshot: `bcd0` changes 3→8 in the 3rd SHOW0 cycle.
   - seg stays 30 for the rest of the frame.
   - Next frame's SHOW0 shows 00.
   - frame_start pulses exactly once per 16 cycles.
5. Invalid codes: `bcd0`=4'hB and `bcd1`=4'hF give seg=3F in both SHOW slots. `blank_lz`=1 does not blank digit 1, since snap1≠0.
6. Sweep `bcd1`:`bcd0` across 00..99 synchronized to frame_start. Every SHOW slot's seg matches the decode table, and `an` is never 2'b00.
